// File: rtl/ofs_plat_avalon_mem_sink_ram_if.sv
// Avalon-MM bus bundle between a memory source (master) and the
// RAM-backed sink (slave). The clock and reset are not part of the bundle.
interface ofs_plat_avalon_mem_sink_ram_if #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_CNT_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]      address;
    logic                       read;
    logic                       write;
    logic [BURST_CNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]      writedata;
    logic [DATA_WIDTH/8-1:0]    byteenable;
    logic                       waitrequest;
    logic [DATA_WIDTH-1:0]      readdata;
    logic                       readdatavalid;
    logic [1:0]                 response;
    logic                       writeresponsevalid;

    modport master (
        output address, read, write, burstcount, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid, response, writeresponsevalid
    );

    modport slave (
        input  address, read, write, burstcount, writedata, byteenable,
        output waitrequest, readdata, readdatavalid, response, writeresponsevalid
    );
endinterface

// File: rtl/ofs_plat_avalon_mem_sink_ram.sv
// Avalon-MM memory sink backed by a word-addressed internal RAM.
// Accepts single and burst reads/writes with byteenable; read beats come
// back in order one cycle after they are issued, one beat per cycle.
// Optional feature macro: OFS_PLAT_AVALON_MEM_SINK_WR_RESP_EN enables a
// one-cycle writeresponsevalid pulse after the last beat of every write burst.
module ofs_plat_avalon_mem_sink_ram #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_CNT_WIDTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    ofs_plat_avalon_mem_sink_ram_if.slave bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    state_t                     r_state;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [BURST_CNT_WIDTH-1:0] r_remain;
    logic                       r_waitrequest;
    logic                       r_readdatavalid;
    logic [DATA_WIDTH-1:0]      r_readdata;
    logic [DATA_WIDTH-1:0]      r_mem [0:DEPTH-1];

    state_t                     w_nextState;
    logic [ADDR_WIDTH-1:0]      w_nextAddr;
    logic [BURST_CNT_WIDTH-1:0] w_nextRemain;
    logic                       w_nextWaitreq;
    logic [BURST_CNT_WIDTH-1:0] w_burstLen;
    logic                       w_memWe;
    logic [ADDR_WIDTH-1:0]      w_memAddr;
    logic                       w_rdIssue;
    logic [ADDR_WIDTH-1:0]      w_rdAddr;

    // A burstcount of zero is handled as a single beat.
    assign w_burstLen = (bus.burstcount == '0) ? BURST_CNT_WIDTH'(1) : bus.burstcount;

    // Next-state, RAM write and read-issue decode for the burst FSM.
    always_comb begin
        w_nextState   = r_state;
        w_nextAddr    = r_addr;
        w_nextRemain  = r_remain;
        w_nextWaitreq = 1'b0;
        w_memWe       = 1'b0;
        w_memAddr     = r_addr;
        w_rdIssue     = 1'b0;
        w_rdAddr      = r_addr;
        case (r_state)
            IDLE: begin
                if (!r_waitrequest) begin
                    if (bus.write) begin
                        w_memWe    = 1'b1;
                        w_memAddr  = bus.address;
                        w_nextAddr = bus.address + ADDR_WIDTH'(1);
                        if (w_burstLen > BURST_CNT_WIDTH'(1)) begin
                            w_nextRemain = w_burstLen - BURST_CNT_WIDTH'(1);
                            w_nextState  = WR_BURST;
                        end
                    end else if (bus.read) begin
                        w_rdIssue  = 1'b1;
                        w_rdAddr   = bus.address;
                        w_nextAddr = bus.address + ADDR_WIDTH'(1);
                        if (w_burstLen > BURST_CNT_WIDTH'(1)) begin
                            w_nextRemain  = w_burstLen - BURST_CNT_WIDTH'(1);
                            w_nextState   = RD_BURST;
                            w_nextWaitreq = 1'b1;
                        end
                    end
                end
            end
            WR_BURST: begin
                if (bus.write) begin
                    w_memWe      = 1'b1;
                    w_memAddr    = r_addr;
                    w_nextAddr   = r_addr + ADDR_WIDTH'(1);
                    w_nextRemain = r_remain - BURST_CNT_WIDTH'(1);
                    if (r_remain == BURST_CNT_WIDTH'(1)) begin
                        w_nextState = IDLE;
                    end
                end
            end
            RD_BURST: begin
                w_rdIssue    = 1'b1;
                w_rdAddr     = r_addr;
                w_nextAddr   = r_addr + ADDR_WIDTH'(1);
                w_nextRemain = r_remain - BURST_CNT_WIDTH'(1);
                if (r_remain == BURST_CNT_WIDTH'(1)) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextWaitreq = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // FSM state, burst tracking and registered read-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remain        <= '0;
            r_waitrequest   <= 1'b1;
            r_readdatavalid <= 1'b0;
            r_readdata      <= '0;
        end else begin
            r_state         <= w_nextState;
            r_addr          <= w_nextAddr;
            r_remain        <= w_nextRemain;
            r_waitrequest   <= w_nextWaitreq;
            r_readdatavalid <= w_rdIssue;
            if (w_rdIssue) begin
                r_readdata <= r_mem[w_rdAddr];
            end
        end
    end

    // RAM byte-lane writes; contents survive reset and start undefined.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (bus.byteenable[b]) begin
                    r_mem[w_memAddr][b*8 +: 8] <= bus.writedata[b*8 +: 8];
                end
            end
        end
    end

`ifdef OFS_PLAT_AVALON_MEM_SINK_WR_RESP_EN
    logic r_wrRespValid;
    logic w_wrDone;

    // A write burst finishes when a beat is written and the FSM lands in IDLE.
    assign w_wrDone = w_memWe && (w_nextState == IDLE);

    // One-cycle completion pulse following the final write beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrRespValid <= 1'b0;
        end else begin
            r_wrRespValid <= w_wrDone;
        end
    end

    assign bus.writeresponsevalid = r_wrRespValid;
`else
    assign bus.writeresponsevalid = 1'b0;
`endif

    assign bus.waitrequest   = r_waitrequest;
    assign bus.readdata      = r_readdata;
    assign bus.readdatavalid = r_readdatavalid;
    assign bus.response      = 2'b00;

`ifndef SYNTHESIS
    // Protocol checks: simultaneous read/write in IDLE, and reads mid write burst.
    a_noRdWrCollision: assert property (@(posedge clk) disable iff (!reset_n)
        !(r_state == IDLE && !r_waitrequest && bus.read && bus.write));
    a_noReadInWrBurst: assert property (@(posedge clk) disable iff (!reset_n)
        !(r_state == WR_BURST && bus.read));
`endif
endmodule

// File: tb/tb_ofs_plat_avalon_mem_sink_ram.sv
// Directed testbench for ofs_plat_avalon_mem_sink_ram.
// Honours OFS_PLAT_AVALON_MEM_SINK_WR_RESP_EN when choosing expected
// writeresponsevalid values.
module tb_ofs_plat_avalon_mem_sink_ram;
`ifdef OFS_PLAT_AVALON_MEM_SINK_WR_RESP_EN
    localparam bit WR_RESP = 1'b1;
`else
    localparam bit WR_RESP = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   nVectors;
    int   nMiscompares;

    ofs_plat_avalon_mem_sink_ram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .BURST_CNT_WIDTH(4)) bus();

    ofs_plat_avalon_mem_sink_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .BURST_CNT_WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idleBus;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.burstcount = 4'd1;
        bus.writedata  = '0;
        bus.byteenable = 8'hFF;
    endtask

    task automatic writeWord(input logic [9:0] a, input logic [63:0] d, input logic [7:0] be);
        bus.write      = 1'b1;
        bus.address    = a;
        bus.burstcount = 4'd1;
        bus.writedata  = d;
        bus.byteenable = be;
        tick();
        bus.write      = 1'b0;
        bus.byteenable = 8'hFF;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idleBus();
        repeat (5) begin
            tick();
            nVectors++;
            if (bus.waitrequest !== 1'b1 || bus.readdatavalid !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL reset_hold: waitrequest=%b readdatavalid=%b, required 1/0",
                         bus.waitrequest, bus.readdatavalid);
            end
        end
        nVectors++;
        if (bus.readdata !== 64'd0 || bus.writeresponsevalid !== 1'b0 || bus.response !== 2'b00) begin
            nMiscompares++;
            $display("[TB] FAIL reset_values: readdata=%h wrv=%b response=%b, required 0/0/00",
                     bus.readdata, bus.writeresponsevalid, bus.response);
        end
        reset_n = 1'b1;
        tick();
        nVectors++;
        if (bus.waitrequest !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_release: waitrequest=%b, required 0", bus.waitrequest);
        end
    endtask

    task automatic test_single;
        writeWord(10'h010, 64'hDEADBEEF_01234567, 8'hFF);
        nVectors++;
        if (bus.writeresponsevalid !== WR_RESP) begin
            nMiscompares++;
            $display("[TB] FAIL single_wrresp: writeresponsevalid=%b, required %b", bus.writeresponsevalid, WR_RESP);
        end
        bus.read       = 1'b1;
        bus.address    = 10'h010;
        bus.burstcount = 4'd1;
        tick();
        bus.read = 1'b0;
        nVectors++;
        if (bus.readdatavalid !== 1'b1 || bus.readdata !== 64'hDEADBEEF_01234567) begin
            nMiscompares++;
            $display("[TB] FAIL single_read: valid=%b data=%h, required 1/deadbeef01234567",
                     bus.readdatavalid, bus.readdata);
        end
        tick();
        nVectors++;
        if (bus.readdatavalid !== 1'b0 || bus.writeresponsevalid !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL single_after: valid=%b wrv=%b, required 0/0",
                     bus.readdatavalid, bus.writeresponsevalid);
        end
    endtask

    task automatic test_byteenable;
        writeWord(10'h005, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
        writeWord(10'h005, 64'h0, 8'h0F);
        bus.read       = 1'b1;
        bus.address    = 10'h005;
        bus.burstcount = 4'd1;
        tick();
        bus.read = 1'b0;
        nVectors++;
        if (bus.readdatavalid !== 1'b1 || bus.readdata !== 64'hFFFFFFFF_00000000) begin
            nMiscompares++;
            $display("[TB] FAIL byteenable_merge: valid=%b data=%h, required 1/ffffffff00000000",
                     bus.readdatavalid, bus.readdata);
        end
        tick();
    endtask

    task automatic test_read_burst_wrap;
        int waitCycles;
        writeWord(10'h3FE, 64'd1, 8'hFF);
        writeWord(10'h3FF, 64'd2, 8'hFF);
        writeWord(10'h000, 64'd3, 8'hFF);
        writeWord(10'h001, 64'd4, 8'hFF);
        bus.read       = 1'b1;
        bus.address    = 10'h3FE;
        bus.burstcount = 4'd4;
        tick();
        bus.read = 1'b0;
        waitCycles = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.waitrequest === 1'b1) waitCycles++;
            nVectors++;
            if (bus.readdatavalid !== 1'b1 || bus.readdata !== 64'(k + 1)
                || bus.waitrequest !== (k < 3)) begin
                nMiscompares++;
                $display("[TB] FAIL wrap_beat%0d: valid=%b data=%0d waitreq=%b, required 1/%0d/%b",
                         k, bus.readdatavalid, bus.readdata, bus.waitrequest, k + 1, (k < 3));
            end
            tick();
        end
        nVectors++;
        if (waitCycles != 3 || bus.readdatavalid !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL wrap_end: waitCycles=%0d valid=%b, required 3/0", waitCycles, bus.readdatavalid);
        end
    endtask

    task automatic test_back_to_back;
        // Three single reads on consecutive edges, the last with burstcount 0
        logic [9:0]  addrs [3];
        logic [63:0] exps  [3];
        addrs[0] = 10'h3FE; exps[0] = 64'd1;
        addrs[1] = 10'h3FF; exps[1] = 64'd2;
        addrs[2] = 10'h001; exps[2] = 64'd4;
        bus.read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.address    = addrs[k];
            bus.burstcount = (k == 2) ? 4'd0 : 4'd1;
            tick();
            nVectors++;
            if (bus.readdatavalid !== 1'b1 || bus.readdata !== exps[k] || bus.waitrequest !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL b2b_read%0d: valid=%b data=%0d waitreq=%b, required 1/%0d/0",
                         k, bus.readdatavalid, bus.readdata, bus.waitrequest, exps[k]);
            end
        end
        bus.read = 1'b0;
        tick();
        nVectors++;
        if (bus.readdatavalid !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL b2b_end: valid=%b, required 0", bus.readdatavalid);
        end
    endtask

    task automatic test_write_burst;
        bus.write      = 1'b1;
        bus.address    = 10'h100;
        bus.burstcount = 4'd8;
        bus.writedata  = 64'd0;
        bus.byteenable = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            nVectors++;
            if (bus.writeresponsevalid !== (WR_RESP && i == 7) || bus.waitrequest !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL wrburst_beat%0d: wrv=%b waitreq=%b, required %b/0",
                         i, bus.writeresponsevalid, bus.waitrequest, (WR_RESP && i == 7));
            end
            // Non-first beats carry junk address/burstcount that must be ignored
            bus.address    = 10'h3FF;
            bus.burstcount = 4'd2;
            bus.writedata  = 64'(i + 1);
            if (i == 7) bus.write = 1'b0;
        end
        tick();
        nVectors++;
        if (bus.writeresponsevalid !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL wrburst_pulse_width: wrv=%b, required 0", bus.writeresponsevalid);
        end
        bus.read       = 1'b1;
        bus.address    = 10'h100;
        bus.burstcount = 4'd8;
        tick();
        bus.read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nVectors++;
            if (bus.readdatavalid !== 1'b1 || bus.readdata !== 64'(i)) begin
                nMiscompares++;
                $display("[TB] FAIL wrburst_readback%0d: valid=%b data=%0d, required 1/%0d",
                         i, bus.readdatavalid, bus.readdata, i);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst;
        bus.read       = 1'b1;
        bus.address    = 10'h100;
        bus.burstcount = 4'd8;
        tick();
        bus.read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nVectors++;
            if (bus.readdatavalid !== 1'b1 || bus.readdata !== 64'(i)) begin
                nMiscompares++;
                $display("[TB] FAIL midrst_beat%0d: valid=%b data=%0d, required 1/%0d",
                         i, bus.readdatavalid, bus.readdata, i);
            end
            if (i < 2) tick();
        end
        reset_n = 1'b0;
        #1;
        nVectors++;
        if (bus.readdatavalid !== 1'b0 || bus.waitrequest !== 1'b1 || bus.readdata !== 64'd0) begin
            nMiscompares++;
            $display("[TB] FAIL midrst_async: valid=%b waitreq=%b data=%h, required 0/1/0",
                     bus.readdatavalid, bus.waitrequest, bus.readdata);
        end
        repeat (2) begin
            tick();
            nVectors++;
            if (bus.readdatavalid !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL midrst_hold: valid=%b, required 0", bus.readdatavalid);
            end
        end
        reset_n = 1'b1;
        tick();
        nVectors++;
        if (bus.readdatavalid !== 1'b0 || bus.waitrequest !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL midrst_release: valid=%b waitreq=%b, required 0/0",
                     bus.readdatavalid, bus.waitrequest);
        end
        bus.read       = 1'b1;
        bus.address    = 10'h010;
        bus.burstcount = 4'd1;
        tick();
        bus.read = 1'b0;
        nVectors++;
        if (bus.readdatavalid !== 1'b1 || bus.readdata !== 64'hDEADBEEF_01234567) begin
            nMiscompares++;
            $display("[TB] FAIL midrst_readback: valid=%b data=%h, required 1/deadbeef01234567",
                     bus.readdatavalid, bus.readdata);
        end
        tick();
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        test_reset();
        test_single();
        test_byteenable();
        test_read_burst_wrap();
        test_back_to_back();
        test_write_burst();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
